// File: rtl/wb_pkg.sv
// Shared types for the writeback path: register addresses, data words and the
// hard-wired zero register.
package wb_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of pending load destination tags, with two combinational
// match ports that compare an address against every valid entry.
module tag_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  reg_addr_t push_tag,
    input  logic      pop,
    input  reg_addr_t match_addr1,
    input  reg_addr_t match_addr2,
    output logic      full,
    output logic      empty,
    output reg_addr_t head,
    output logic      match1,
    output logic      match2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    reg_addr_t        mem_q [DEPTH];
    reg_addr_t        mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;
    logic [DEPTH-1:0] valid, hit1, hit2;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_tag;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Entry contents need no reset: validity comes only from the pointers and count.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] offset;
            // An entry is live when its distance from the read pointer is below the count.
            assign offset    = PW'(gi) - rd_ptr_q;
            assign valid[gi] = ({1'b0, offset} < count_q);
            assign hit1[gi]  = valid[gi] && (mem_q[gi] == match_addr1);
            assign hit2[gi]  = valid[gi] && (mem_q[gi] == match_addr2);
        end
    endgenerate

    assign match1 = |hit1;
    assign match2 = |hit2;

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port owner: merges unstallable ALU results with in-order
// load responses and flags read addresses that still wait on a load.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        load_issue_valid,
    input  logic [4:0]  load_issue_rd,
    output logic        load_issue_ready,
    input  logic        load_resp_valid,
    input  logic [31:0] load_resp_data,
    output logic        load_resp_ready,
    input  logic [4:0]  rs1_address,
    output logic        rs1_busy,
    input  logic [4:0]  rs2_address,
    output logic        rs2_busy,
    output logic [4:0]  rd_address,
    output logic        rd_write_enable,
    output logic [31:0] rd_write_data
);

    logic      fifo_full, fifo_empty;
    logic      fifo_match1, fifo_match2;
    reg_addr_t head_tag;
    logic      alu_write, push, pop;

    tag_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_tag   (load_issue_rd),
        .pop        (pop),
        .match_addr1(rs1_address),
        .match_addr2(rs2_address),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head_tag),
        .match1     (fifo_match1),
        .match2     (fifo_match2)
    );

    assign alu_write = alu_valid && (alu_rd != REG_ZERO);

    // A load bound for x0 never needs the write port, so it may drain under an ALU write.
    assign load_resp_ready  = !reset && !fifo_empty && !(alu_write && (head_tag != REG_ZERO));
    assign load_issue_ready = !reset && !fifo_full;

    assign push = load_issue_valid && load_issue_ready;
    assign pop  = load_resp_valid && load_resp_ready;

    assign rs1_busy = !reset && (rs1_address != REG_ZERO) && fifo_match1;
    assign rs2_busy = !reset && (rs2_address != REG_ZERO) && fifo_match2;

    always_comb begin
        rd_write_enable = 1'b0;
        rd_address      = REG_ZERO;
        rd_write_data   = '0;
        if (!reset) begin
            if (alu_write) begin
                rd_write_enable = 1'b1;
                rd_address      = alu_rd;
                rd_write_data   = alu_data;
            end else if (pop && (head_tag != REG_ZERO)) begin
                rd_write_enable = 1'b1;
                rd_address      = head_tag;
                rd_write_data   = load_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus randomized
// traffic scored against a queue-based model of the pending loads.
module tb_writeback_unit;

    localparam int MAX = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        load_issue_valid;
    logic [4:0]  load_issue_rd;
    logic        load_issue_ready;
    logic        load_resp_valid;
    logic [31:0] load_resp_data;
    logic        load_resp_ready;
    logic [4:0]  rs1_address;
    logic        rs1_busy;
    logic [4:0]  rs2_address;
    logic        rs2_busy;
    logic [4:0]  rd_address;
    logic        rd_write_enable;
    logic [31:0] rd_write_data;

    int n_cmp  = 0;
    int n_fail = 0;

    // Pending load destinations, oldest first.
    logic [4:0] mq[$];

    always #5 clock = ~clock;

    writeback_unit #(
        .MAX_OUTSTANDING(MAX)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .load_issue_valid(load_issue_valid),
        .load_issue_rd   (load_issue_rd),
        .load_issue_ready(load_issue_ready),
        .load_resp_valid (load_resp_valid),
        .load_resp_data  (load_resp_data),
        .load_resp_ready (load_resp_ready),
        .rs1_address     (rs1_address),
        .rs1_busy        (rs1_busy),
        .rs2_address     (rs2_address),
        .rs2_busy        (rs2_busy),
        .rd_address      (rd_address),
        .rd_write_enable (rd_write_enable),
        .rd_write_data   (rd_write_data)
    );

    function automatic logic m_busy(input logic [4:0] a);
        if (reset || a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_issue_ready();
        return !reset && (mq.size() < MAX);
    endfunction

    function automatic logic m_resp_ready();
        if (reset || mq.size() == 0) return 1'b0;
        return !(alu_valid && alu_rd != 5'd0 && mq[0] != 5'd0);
    endfunction

    // Decode must never let the ALU target a register with a pending load.
    always @(negedge clock) begin
        assert (!alu_valid || !m_busy(alu_rd))
            else $error("WAW hazard driven by bench on x%0d", alu_rd);
    end

    task automatic idle_inputs();
        reset            = 1'b0;
        alu_valid        = 1'b0;
        alu_rd           = 5'd0;
        alu_data         = 32'd0;
        load_issue_valid = 1'b0;
        load_issue_rd    = 5'd0;
        load_resp_valid  = 1'b0;
        load_resp_data   = 32'd0;
        rs1_address      = 5'd0;
        rs2_address      = 5'd0;
    endtask

    // Advance one clock and update the model with the handshakes of that edge.
    task automatic tick();
        logic do_push, do_pop;
        do_push = load_issue_valid && m_issue_ready();
        do_pop  = load_resp_valid && m_resp_ready();
        @(posedge clock);
        if (reset) mq.delete();
        else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(load_issue_rd);
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1; load_issue_valid = 1'b1; load_issue_rd = 5'd7;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hCAFE_F00D; rs1_address = 5'd7;
        #4;
        n_cmp++;
        if ({rd_write_enable, rd_address, rd_write_data, load_issue_ready, load_resp_ready, rs1_busy, rs2_busy} !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%b rd=%0d data=%h ir=%b rr=%b b1=%b b2=%b, want all 0",
                     rd_write_enable, rd_address, rd_write_data, load_issue_ready, load_resp_ready, rs1_busy, rs2_busy);
        end
        tick();
        idle_inputs(); rs1_address = 5'd7;
        #4;
        n_cmp++;
        if ({load_issue_ready, rs1_busy, load_resp_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL after_reset: got ir=%b b1=%b rr=%b, want ir=1 b1=0 rr=0",
                     load_issue_ready, rs1_busy, load_resp_ready);
        end
        $display("txn reset done");
        tick();
    endtask

    task automatic test_alu();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        #4;
        n_cmp++;
        if ({rd_write_enable, rd_address, rd_write_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL alu_write: got we=%b rd=%0d data=%h, want 1/5/deadbeef", rd_write_enable, rd_address, rd_write_data);
        end
        $display("txn alu x5 = deadbeef");
        tick();
        alu_rd = 5'd0;
        #4;
        n_cmp++;
        if ({rd_write_enable, rd_address, rd_write_data} !== 38'd0) begin
            n_fail++;
            $display("FAIL alu_x0: got we=%b rd=%0d data=%h, want 0/0/0", rd_write_enable, rd_address, rd_write_data);
        end
        tick();
    endtask

    task automatic test_load_basic();
        idle_inputs();
        load_issue_valid = 1'b1; load_issue_rd = 5'd7;
        #4;
        n_cmp++;
        if (load_issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready: got %b want 1", load_issue_ready);
        end
        tick();
        idle_inputs(); rs1_address = 5'd7;
        #4;
        n_cmp++;
        if ({rs1_busy, rd_write_enable} !== 2'b10) begin
            n_fail++;
            $display("FAIL busy_after_issue: got b1=%b we=%b want 1/0", rs1_busy, rd_write_enable);
        end
        tick();
        load_resp_valid = 1'b1; load_resp_data = 32'h1234_5678;
        #4;
        n_cmp++;
        if ({load_resp_ready, rd_write_enable, rd_address, rd_write_data, rs1_busy} !== {1'b1, 1'b1, 5'd7, 32'h1234_5678, 1'b1}) begin
            n_fail++;
            $display("FAIL load_write: got rr=%b we=%b rd=%0d data=%h b1=%b want 1/1/7/12345678/1",
                     load_resp_ready, rd_write_enable, rd_address, rd_write_data, rs1_busy);
        end
        $display("txn load x7 = 12345678");
        tick();
        load_resp_valid = 1'b0;
        #4;
        n_cmp++;
        if (rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_pop: got %b want 0", rs1_busy);
        end
        tick();
    endtask

    task automatic test_alu_priority();
        idle_inputs();
        load_issue_valid = 1'b1; load_issue_rd = 5'd9;
        tick();
        idle_inputs();
        load_resp_valid = 1'b1; load_resp_data = 32'hA5A5_0009;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0333;
        #4;
        n_cmp++;
        if ({load_resp_ready, rd_write_enable, rd_address, rd_write_data} !== {1'b0, 1'b1, 5'd3, 32'h0000_0333}) begin
            n_fail++;
            $display("FAIL alu_priority: got rr=%b we=%b rd=%0d data=%h want 0/1/3/00000333",
                     load_resp_ready, rd_write_enable, rd_address, rd_write_data);
        end
        tick();
        alu_valid = 1'b0;
        #4;
        n_cmp++;
        if ({load_resp_ready, rd_write_enable, rd_address, rd_write_data} !== {1'b1, 1'b1, 5'd9, 32'hA5A5_0009}) begin
            n_fail++;
            $display("FAIL stalled_load: got rr=%b we=%b rd=%0d data=%h want 1/1/9/a5a50009",
                     load_resp_ready, rd_write_enable, rd_address, rd_write_data);
        end
        $display("txn alu x3 then load x9");
        tick();
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            idle_inputs();
            for (int i = 1; i <= 4; i++) begin
                load_issue_valid = 1'b1; load_issue_rd = 5'(i);
                #4;
                n_cmp++;
                if (load_issue_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fill_ready r%0d i%0d: got %b want 1", r, i, load_issue_ready);
                end
                tick();
            end
            load_issue_rd = 5'd5;
            load_resp_valid = 1'b1; load_resp_data = 32'h100 * r + 1;
            #4;
            n_cmp++;
            if ({load_issue_ready, rd_write_enable, rd_address, rd_write_data} !== {1'b0, 1'b1, 5'd1, 32'h100 * r + 1}) begin
                n_fail++;
                $display("FAIL full_pop r%0d: got ir=%b we=%b rd=%0d data=%h want 0/1/1/%h",
                         r, load_issue_ready, rd_write_enable, rd_address, rd_write_data, 32'h100 * r + 1);
            end
            tick();
            load_issue_valid = 1'b0;
            for (int i = 2; i <= 4; i++) begin
                load_resp_data = 32'h100 * r + i;
                #4;
                n_cmp++;
                if ({load_issue_ready, rd_write_enable, rd_address, rd_write_data} !== {1'b1, 1'b1, 5'(i), 32'h100 * r + i}) begin
                    n_fail++;
                    $display("FAIL drain r%0d i%0d: got ir=%b we=%b rd=%0d data=%h",
                             r, i, load_issue_ready, rd_write_enable, rd_address, rd_write_data);
                end
                tick();
            end
            $display("txn round %0d: x1..x4 filled and drained", r);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_rd_zero();
        idle_inputs();
        load_issue_valid = 1'b1; load_issue_rd = 5'd0;
        tick();
        load_issue_rd = 5'd6;
        tick();
        idle_inputs();
        load_resp_valid = 1'b1; load_resp_data = 32'h0BAD_0000;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2222_2222;
        #4;
        n_cmp++;
        if ({load_resp_ready, rd_write_enable, rd_address, rd_write_data, rs2_busy} !== {1'b1, 1'b1, 5'd2, 32'h2222_2222, 1'b0}) begin
            n_fail++;
            $display("FAIL x0_resp: got rr=%b we=%b rd=%0d data=%h b2=%b want 1/1/2/22222222/0",
                     load_resp_ready, rd_write_enable, rd_address, rd_write_data, rs2_busy);
        end
        tick();
        #4;
        n_cmp++;
        if ({load_resp_ready, rd_address, rs2_busy} !== {1'b0, 5'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL x6_stall: got rr=%b rd=%0d b2=%b want 0/2/0", load_resp_ready, rd_address, rs2_busy);
        end
        tick();
        idle_inputs(); rs2_address = 5'd6;
        #4;
        n_cmp++;
        if (rs2_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL x6_busy: got %b want 1", rs2_busy);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; load_resp_valid = 1'b1;
        #4;
        n_cmp++;
        if ({rs2_busy, load_resp_ready, rd_write_enable} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_discard: got b2=%b rr=%b we=%b want 0/0/0", rs2_busy, load_resp_ready, rd_write_enable);
        end
        $display("txn x0/x6 loads, reset discards x6");
        tick();
    endtask

    task automatic test_random();
        logic        e_we, e_ir, e_rr;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        for (int c = 0; c < 500; c++) begin
            reset            = ($urandom_range(0, 59) == 0);
            load_issue_valid = $urandom_range(0, 1) == 1;
            load_issue_rd    = 5'($urandom_range(0, 7));
            load_resp_valid  = $urandom_range(0, 1) == 1;
            load_resp_data   = $urandom;
            alu_valid        = $urandom_range(0, 2) == 0;
            alu_rd           = 5'($urandom_range(0, 7));
            if (m_busy(alu_rd)) alu_rd = 5'd0;
            alu_data         = $urandom;
            rs1_address      = 5'($urandom_range(0, 7));
            rs2_address      = 5'($urandom_range(0, 7));
            e_ir = m_issue_ready();
            e_rr = m_resp_ready();
            e_we = 1'b0; e_rd = 5'd0; e_data = 32'd0;
            if (!reset && alu_valid && alu_rd != 5'd0) begin
                e_we = 1'b1; e_rd = alu_rd; e_data = alu_data;
            end else if (load_resp_valid && e_rr && mq[0] != 5'd0) begin
                e_we = 1'b1; e_rd = mq[0]; e_data = load_resp_data;
            end
            #4;
            n_cmp++;
            if ({rd_write_enable, rd_address, rd_write_data, load_issue_ready, load_resp_ready, rs1_busy, rs2_busy} !==
                {e_we, e_rd, e_data, e_ir, e_rr, m_busy(rs1_address), m_busy(rs2_address)}) begin
                n_fail++;
                $display("FAIL random c%0d: got we=%b rd=%0d d=%h ir=%b rr=%b b1=%b b2=%b want we=%b rd=%0d d=%h ir=%b rr=%b b1=%b b2=%b",
                         c, rd_write_enable, rd_address, rd_write_data, load_issue_ready, load_resp_ready, rs1_busy, rs2_busy,
                         e_we, e_rd, e_data, e_ir, e_rr, m_busy(rs1_address), m_busy(rs2_address));
            end
            if (e_we) $display("txn random c%0d: x%0d = %h", c, e_rd, e_data);
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_alu();
        test_load_basic();
        test_alu_priority();
        test_back_to_back();
        test_rd_zero();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Owns the register file's single write port (rd_address / rd_write_enable / rd_write_data) for the pipeline.
- Merges two result sources: single-cycle ALU results, which cannot be stalled, and variable-latency load responses, which use a valid/ready handshake.
- Tracks outstanding loads in an in-order destination-tag FIFO.
- Reports per-read-port busy flags so decode can stall on RAW hazards against pending loads.

Parameters:
MAX_OUTSTANDING, 4, maximum in-flight loads; power of two, >= 2; sets tag FIFO depth.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU result present this cycle; never stalled
alu_rd  input  5  ALU destination register
alu_data  input  32  ALU result
load_issue_valid  input  1  load issued this cycle
load_issue_rd  input  5  destination register of issued load
load_issue_ready  output  1  tag FIFO can accept an issue
load_resp_valid  input  1  load response data present
load_resp_data  input  32  load response data; responses arrive in issue order
load_resp_ready  output  1  response accepted this cycle
rs1_address  input  5  decode read-port-1 address to check
rs1_busy  output  1  rs1_address has a pending load
rs2_address  input  5  decode read-port-2 address to check
rs2_busy  output  1  rs2_address has a pending load
rd_address  output  5  regfile write address
rd_write_enable  output  1  regfile write strobe
rd_write_data  output  32  regfile write data

Behaviour:
- State: tag FIFO of MAX_OUTSTANDING x 5-bit entries, read/write pointers of width $clog2(MAX_OUTSTANDING) that wrap modulo depth, and an occupancy count of width $clog2(MAX_OUTSTANDING)+1.
- Reset (synchronous):
  - Pointers and count cleared on the edge.
  - While reset is high, all outputs are forced to 0: rd_*, load_*_ready, rs*_busy.
  - Reset mid-operation discards all pending tags; late responses after reset see ready=0.
- Write port is combinational: regfile writes on the same edge; zero added latency.
- Arbitration, with ALU having strict priority:
  - alu_valid && alu_rd!=0: rd_write_enable=1, rd_address=alu_rd, rd_write_data=alu_data.
  - Else if the load response handshake fires and head tag !=0: rd_write_enable=1, rd_address=head tag, rd_write_data=load_resp_data.
  - Else rd_write_enable=0, rd_address=0, rd_write_data=0.
- load_resp_ready = count!=0 && !(alu_valid && alu_rd!=0 && head tag!=0).
  - A head tag of x0 is accepted even during an ALU write.
  - A response with an empty FIFO is ignored (ready=0).
  - Handshake = load_resp_valid && load_resp_ready; it pops the head.
- load_issue_ready = count < MAX_OUTSTANDING.
  - Registered-state only; there is no same-cycle pop credit, so a full FIFO refuses issue even while popping.
  - Issue handshake pushes load_issue_rd, including rd=0, to preserve response ordering.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Busy flags:
  - rsN_busy = (rsN_address!=0) && any valid FIFO entry equals rsN_address, including the head.
  - Busy therefore stays high in the cycle the load writes back, because the regfile is not write-through. It drops the cycle after the pop.
  - A push is visible on busy from the next cycle.
- Protocol rules:
  - alu_valid with alu_rd matching a valid FIFO entry (WAW) is illegal; decode prevents it by checking busy.
  - The bench flags it with an assertion.

Decomposition:
- Package wb_pkg: typedef reg_addr_t (logic [4:0]), typedef word_t (logic [31:0]), constant REG_ZERO = 5'd0.
- Sub-module tag_fifo, parameterised by depth:
  - Interface: push/pop/full/empty/head.
  - Combinational two-port match outputs (match1/match2) against valid entries.
- writeback_unit holds the arbitration and ready logic.

Test Plan:
- Reset for one cycle with load_issue_valid=1 and alu_valid=1 -> all outputs 0 that cycle; afterwards load_issue_ready=1, rs1_busy=0, FIFO empty (issue dropped).
- alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF -> same cycle rd_write_enable=1, rd_address=5, rd_write_data=32'hDEADBEEF; alu_rd=0 -> rd_write_enable=0.
- Issue load rd=7; next cycle rs1_address=7 -> rs1_busy=1; respond with 32'h12345678 -> load_resp_ready=1, write rd=7, rs1_busy still 1; following cycle rs1_busy=0.
- Head tag rd=9 pending, load_resp_valid=1 and alu_valid=1 with alu_rd=3 -> ALU write to x3, load_resp_ready=0. Next cycle with alu_valid=0 -> write x9 with load data.
- Issue rd=1,2,3,4 back-to-back -> load_issue_ready=0 after the 4th. Issue attempt while popping -> refused. Responses write x1..x4 in order. Ready returns the cycle after the first pop. Pointer wrap checked over 3 fill/drain rounds.
- Issue rd=0 then rd=6; respond twice with alu_valid=1, alu_rd=2:
  - 1st response: accepted, rd_write_enable from ALU only.
  - 2nd response: stalled.
  - rs2_address=0 -> rs2_busy=0 throughout.
  - Assert reset with rd=6 pending -> rs2_address=6 busy=0 and load_resp_ready=0 afterwards.
